// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   UART/RS422 receive front end. Samples one serial line, assembles 8N1
//   bytes LSB first, and buffers them in a first-word-fall-through FIFO that
//   a valid/ready consumer drains. One instance per RS422 channel.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> 8E1 frames, a PARITY state after DATA, extra port parity_err
//   undefined -> 8N1 frames only, no parity_err port
//
// Parameters
//   CLK_FRE     sys_clk frequency in MHz
//   BAUD_RATE   line rate in bits/s
//   FIFO_DEPTH  receive FIFO entries (power of 2, >= 2)
//
// Ports
//   sys_clk     in   1  system clock, rising edge
//   rst         in   1  asynchronous reset, active high
//   uart_rx     in   1  serial input, idle high, asynchronous to sys_clk
//   rx_data     out  8  FIFO head byte, valid while rx_valid = 1
//   rx_valid    out  1  FIFO not empty
//   rx_ready    in   1  consumer takes the head when rx_valid & rx_ready
//   fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy 0..FIFO_DEPTH
//   frame_err   out  1  one-cycle pulse, stop bit sampled low
//   overflow    out  1  one-cycle pulse, byte arrived while full and dropped
//   parity_err  out  1  (UART_RX_PARITY_EN only) one-cycle pulse, bad parity
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int CLK_FRE    = 200,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          sys_clk,
    input  logic                          rst,
    input  logic                          uart_rx,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                          parity_err,
`endif
    output logic                          overflow
);

    localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
    localparam int CNT_W = $clog2(CYCLE);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CYCLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLE - 1);
    localparam logic [CW-1:0]    CNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer and edge detector
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_sync_q;
    logic rx_dly_q;
    logic fall_s;

    // Two-flop synchronizer plus one delay stage; idles high out of reset.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_dly_q  <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_dly_q  <= rx_sync_q;
        end
    end

    assign fall_s = rx_dly_q & ~rx_sync_q;

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             push_s;
    logic             frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic             par_bit_q, par_bit_d;
    logic             parity_err_q, parity_err_d;
`endif

    // Even parity: data bits XOR parity bit must be zero.
    function automatic logic parity_bad(input logic [7:0] data, input logic par);
        parity_bad = ^{data, par};
    endfunction

    // FSM state, bit timer, bit counter and shift register.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Next-state logic; START samples at half bit so later samples land at
    // bit centres on every full-bit wrap of the timer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        push_s      = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (fall_s) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_cnt_d = 3'd0;
                    if (rx_sync_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d              = '0;
                    shift_d[bit_cnt_q] = rx_sync_q;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    par_bit_d = rx_sync_q;
                    state_d   = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
`endif
            S_STOP: begin
                // Back to IDLE at the stop-bit centre so a following start
                // edge is never missed.
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (!rx_sync_q) begin
                        frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (parity_bad(shift_q, par_bit_q)) begin
                        parity_err_d = 1'b1;
`endif
                    end else begin
                        push_s = 1'b1;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // First-word-fall-through FIFO with registered head
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          overflow_q, overflow_d;
    logic          pop_s;
    logic          full_s;
    logic          wr_en_s;
    logic [7:0]    head_s;

    // Pointer, occupancy and head arithmetic.
    always_comb begin
        pop_s   = rx_valid_q & rx_ready;
        full_s  = (count_q == CNT_FULL);
        // A full FIFO still accepts a push when the head leaves this cycle.
        wr_en_s    = push_s & (~full_s | pop_s);
        overflow_d = push_s & full_s & ~pop_s;

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_en_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // The next head may be the byte being written this very cycle.
        if (wr_en_s && (wr_ptr_q == rd_ptr_d)) begin
            head_s = shift_q;
        end else begin
            head_s = mem_q[rd_ptr_d];
        end

        rx_valid_d = (count_d != CW'(0));
        if (rx_valid_d) begin
            rx_data_d = head_s;
        end else begin
            rx_data_d = rx_data_q;
        end
    end

    // FIFO storage; contents are qualified by the pointers, so no reset.
    always_ff @(posedge sys_clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    // FIFO pointers, occupancy, head register and overflow pulse.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign fifo_count = count_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a shortened bit period (16 clocks).
// Expected bytes are queued when a good frame is driven and compared when the
// DUT hands them over on rx_valid & rx_ready.
module tb_uart_rx_fifo;

    localparam int CYC   = 16;
    localparam int DEPTH = 16;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic       uart_rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [4:0] fifo_count;
    logic       frame_err;
    logic       overflow;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int         n_cmp  = 0;
    int         n_bad  = 0;
    int         n_pop  = 0;
    int         n_ferr = 0;
    int         n_ovf  = 0;
    int         n_perr = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo #(
        .CLK_FRE    (200),
        .BAUD_RATE  (12_500_000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .overflow   (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor on the falling edge: pulse counters and scoreboard pops.
    always @(negedge sys_clk) begin
        if (!rst) begin
            if (frame_err) n_ferr++;
            if (overflow)  n_ovf++;
`ifdef UART_RX_PARITY_EN
            if (parity_err) n_perr++;
`endif
            if (rx_valid && rx_ready) begin
                n_pop++;
                check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic bit_time(input logic b);
        uart_rx = b;
        repeat (CYC) @(posedge sys_clk);
        #1;
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic stop_b);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
        bit_time(^d);
`endif
        bit_time(stop_b);
        uart_rx = 1'b1;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_p(input logic [7:0] d, input logic par);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(d[i]);
        bit_time(par);
        bit_time(1'b1);
    endtask
`endif

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_valid"},   32'(rx_valid),   32'd0);
        check({tag, "_rx_data"},    32'(rx_data),    32'd0);
        check({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
        check({tag, "_frame_err"},  32'(frame_err),  32'd0);
        check({tag, "_overflow"},   32'(overflow),   32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        uart_rx  = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check_reset_outputs("rst0");
        rst = 1'b0;
        idle(4);

        // 1: two back-to-back bytes with the consumer always ready
        rx_ready = 1'b1;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hA3);
        send(8'h55, 1'b1);
        send(8'hA3, 1'b1);
        idle(2 * CYC);
        check("t1_pops",  32'(n_pop), 32'd2);
        check("t1_sb",    32'(exp_q.size()), 32'd0);
        check("t1_ferr",  32'(n_ferr), 32'd0);
        check("t1_ovf",   32'(n_ovf), 32'd0);

        // 2: short low glitch must be rejected, then a real byte still lands
        uart_rx = 1'b0;
        repeat (CYC / 4) @(posedge sys_clk);
        #1;
        idle(3 * CYC);
        check("t2_valid", 32'(rx_valid), 32'd0);
        check("t2_count", 32'(fifo_count), 32'd0);
        check("t2_ferr",  32'(n_ferr), 32'd0);
        exp_q.push_back(8'h96);
        send(8'h96, 1'b1);
        idle(2 * CYC);
        check("t2_pops",  32'(n_pop), 32'd3);

        // 3: bad stop bit
        send(8'h3C, 1'b0);
        idle(2 * CYC);
        check("t3_ferr",  32'(n_ferr), 32'd1);
        check("t3_count", 32'(fifo_count), 32'd0);
        check("t3_pops",  32'(n_pop), 32'd3);

        // 4: fill to full with the consumer stalled, one byte overflows
        rx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < DEPTH) exp_q.push_back(8'(i));
            send(8'(i), 1'b1);
            if (i == DEPTH - 1) begin
                check("t4_full_count", 32'(fifo_count), 32'd16);
                check("t4_no_ovf_yet", 32'(n_ovf), 32'd0);
            end
        end
        idle(4);
        check("t4_ovf",   32'(n_ovf), 32'd1);
        check("t4_count", 32'(fifo_count), 32'd16);
        check("t4_head",  32'(rx_data), 32'h00);
        check("t4_valid", 32'(rx_valid), 32'd1);
        rx_ready = 1'b1;
        repeat (DEPTH + 4) @(posedge sys_clk);
        #1;
        check("t4_sb",       32'(exp_q.size()), 32'd0);
        check("t4_pops",     32'(n_pop), 32'd19);
        check("t4_valid_lo", 32'(rx_valid), 32'd0);
        check("t4_count_lo", 32'(fifo_count), 32'd0);

        // 5: reset in the middle of a frame with a byte already buffered
        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        send(8'h11, 1'b1);
        idle(2);
        check("t5_pre_count", 32'(fifo_count), 32'd1);
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(1'((8'h81 >> i) & 8'h01));
        uart_rx = 1'b0;
        repeat (CYC / 2) @(posedge sys_clk);
        #1;
        rst     = 1'b1;
        uart_rx = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        check_reset_outputs("t5_rst");
        exp_q.delete();
        rst = 1'b0;
        idle(2 * CYC);
        check("t5_count_after", 32'(fifo_count), 32'd0);
        rx_ready = 1'b1;
        exp_q.push_back(8'h7E);
        send(8'h7E, 1'b1);
        idle(2 * CYC);
        check("t5_pops",  32'(n_pop), 32'd20);
        check("t5_sb",    32'(exp_q.size()), 32'd0);
        check("t5_ferr",  32'(n_ferr), 32'd1);
        check("t5_ovf",   32'(n_ovf), 32'd1);

`ifdef UART_RX_PARITY_EN
        // 6: good parity accepted, bad parity dropped
        exp_q.push_back(8'h07);
        send_p(8'h07, 1'b1);
        send_p(8'h07, 1'b0);
        idle(2 * CYC);
        check("t6_perr",  32'(n_perr), 32'd1);
        check("t6_pops",  32'(n_pop), 32'd21);
        check("t6_count", 32'(fifo_count), 32'd0);
        check("t6_ferr",  32'(n_ferr), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
